// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the PC redirect controller.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        HANDLER = 2'd2,
        HALT    = 2'd3
    } pc_state_t;

    localparam logic [31:0] EXC_VEC_ADDR_DEF = 32'h0000_0180;
    localparam int          CAUSE_W_DEF      = 5;

    localparam logic [CAUSE_W_DEF-1:0] CAUSE_INT  = 5'd0;
    localparam logic [CAUSE_W_DEF-1:0] CAUSE_ADEL = 5'd4;
    localparam logic [CAUSE_W_DEF-1:0] CAUSE_OVF  = 5'd12;

endpackage

// File: rtl/pc_redirect_ctrl.sv
// PC redirect arbiter: exception entry/return, branch, jump and stall
// selection with EPC/CAUSE capture and double-fault halt.
module pc_redirect_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VEC_ADDR = EXC_VEC_ADDR_DEF,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          CAUSE_W      = CAUSE_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hazard_in,
    input  logic               jump_req,
    input  logic               branch_taken,
    input  logic               exc_req,
    input  logic [CAUSE_W-1:0] exc_cause,
    input  logic [31:0]        exc_pc,
    input  logic               eret_req,
    output logic               hazard_detected,
    output logic               br_ctrl_mux_sel,
    output logic               jump_ctrl,
    output logic               load_exceptn_vec_addr,
    output logic [31:0]        exception_vec_addr,
    output logic               flush_if,
    output logic               flush_id,
    output logic               flush_ex,
    output logic [31:0]        epc,
    output logic [CAUSE_W-1:0] cause,
    output logic [7:0]         exc_count,
    output logic               in_handler,
    output logic               halted
);

    pc_state_t          state_q, state_d;
    logic [31:0]        epc_q, epc_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic [7:0]         exc_count_q, exc_count_d;
    logic [2:0]         flush_cnt_q, flush_cnt_d;

    logic active, exc_fire, dbl_fault, eret_fire, br_fire, jmp_fire, exc_redirect;

    // Redirect sources are only honoured in RUN/HANDLER; FLUSH and HALT mask them.
    assign active       = (state_q == RUN) || (state_q == HANDLER);
    assign exc_fire     = exc_req && (state_q == RUN);
    assign dbl_fault    = exc_req && (state_q == HANDLER);
    assign exc_redirect = exc_fire || dbl_fault;
    assign eret_fire    = eret_req && (state_q == HANDLER) && !exc_req && !hazard_in;
    assign br_fire      = branch_taken && active && !exc_redirect && !eret_fire;
    assign jmp_fire     = jump_req && !branch_taken && !hazard_in && active
                          && !exc_redirect && !eret_fire;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            epc_q       <= '0;
            cause_q     <= '0;
            exc_count_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            epc_q       <= epc_d;
            cause_q     <= cause_d;
            exc_count_q <= exc_count_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        epc_d       = epc_q;
        cause_d     = cause_q;
        exc_count_d = exc_count_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            RUN: begin
                if (exc_fire) begin
                    epc_d       = exc_pc;
                    cause_d     = exc_cause;
                    exc_count_d = (exc_count_q == 8'hFF) ? exc_count_q : exc_count_q + 8'd1;
                    flush_cnt_d = 3'(FLUSH_CYCLES - 1);
                    state_d     = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_cnt_q == 3'd0) state_d = HANDLER;
                else                     flush_cnt_d = flush_cnt_q - 3'd1;
            end
            HANDLER: begin
                if (dbl_fault)      state_d = HALT;
                else if (eret_fire) state_d = RUN;
            end
            default: state_d = HALT;
        endcase
    end

    always_comb begin
        hazard_detected       = 1'b0;
        br_ctrl_mux_sel       = 1'b0;
        jump_ctrl             = 1'b0;
        load_exceptn_vec_addr = 1'b0;
        exception_vec_addr    = EXC_VEC_ADDR;
        flush_if              = 1'b0;
        flush_id              = 1'b0;
        flush_ex              = 1'b0;
        if (state_q == HALT) begin
            hazard_detected = 1'b1;
        end else begin
            hazard_detected = hazard_in && !(exc_redirect || eret_fire || br_fire);
            if (exc_redirect) begin
                load_exceptn_vec_addr = 1'b1;
                flush_if              = 1'b1;
                flush_id              = 1'b1;
                flush_ex              = 1'b1;
            end else if (eret_fire) begin
                load_exceptn_vec_addr = 1'b1;
                exception_vec_addr    = epc_q;
                flush_if              = 1'b1;
            end else if (br_fire) begin
                br_ctrl_mux_sel = 1'b1;
                flush_if        = 1'b1;
                flush_id        = 1'b1;
            end else if (jmp_fire) begin
                jump_ctrl = 1'b1;
                flush_if  = 1'b1;
            end
            if (state_q == FLUSH) begin
                flush_id = 1'b1;
                flush_ex = 1'b1;
            end
        end
    end

    assign epc        = epc_q;
    assign cause      = cause_q;
    assign exc_count  = exc_count_q;
    assign in_handler = (state_q == FLUSH) || (state_q == HANDLER);
    assign halted     = (state_q == HALT);

    a_pc_sel_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({br_ctrl_mux_sel, jump_ctrl, load_exceptn_vec_addr}));

endmodule
